filt_ctrl_sched: RTL and testbench

FILT_CTRL_SCHED -- requirements
Module: filt_ctrl_sched

---
 rtl/video_pkg.sv | 20 ++
 rtl/vid_sideband_if.sv | 12 +
 rtl/sof_watchdog.sv | 34 +++
 rtl/filt_ctrl_sched.sv | 157 +++++++++++++++
 tb/tb_filt_ctrl_sched.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// video_pkg : shared greyscale-filter ctrl type and scheduler state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package video_pkg;

   typedef struct packed {
      logic sel709;
      logic en;
   } filt_ctrl_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      HOLD = 2'd2
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/vid_sideband_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vid_sideband_if : video stream sideband (frame start marker)
// Rev 1.0
// ---------------------------------------------------------------------------
interface vid_sideband_if;
   logic sof;

   modport source (output sof);
   modport sink   (input  sof);
endinterface
`default_nettype wire

// File: rtl/sof_watchdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sof_watchdog : flags a missing sof after TIMEOUT_CYC cycles of waiting
// Rev 1.0
// ---------------------------------------------------------------------------
module sof_watchdog #(
   parameter int TOW         = 24,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic expire
);

   localparam logic [TOW-1:0] c_limit = TOW'(TIMEOUT_CYC - 1);

   logic [TOW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!en || clr) begin
         r_cnt <= '0;
      end else if (r_cnt != c_limit) begin
         r_cnt <= r_cnt + TOW'(1);
      end
   end

   assign expire = en && !clr && (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/filt_ctrl_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// filt_ctrl_sched : frame-aligned ctrl commit/override scheduler for the
// greyscale filter; optional sof watchdog under FILT_SCHED_TIMEOUT_EN
// Rev 1.0
// ---------------------------------------------------------------------------
module filt_ctrl_sched
   import video_pkg::*;
#(
   parameter int FCW         = 16,
   parameter int TOW         = 24,
   parameter int TIMEOUT_CYC = 2000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [1:0]       cfg_ctrl,
   input  logic [7:0]       cfg_frames,
   vid_sideband_if.sink     sb_mon,
   output logic [1:0]       ctrl_out,
   output logic             commit,
   output logic [FCW-1:0]   frame_cnt,
   output logic             busy
`ifdef FILT_SCHED_TIMEOUT_EN
   ,
   output logic             timeout
`endif
);

   sched_state_t   r_state, w_state_nx;
   filt_ctrl_t     r_ctrl, w_ctrl_nx;
   filt_ctrl_t     r_base, w_base_nx;
   filt_ctrl_t     r_shadow_ctrl;
   logic [7:0]     r_shadow_frames;
   logic [7:0]     r_rem, w_rem_nx;
   logic           r_commit, w_commit_nx;
   logic [FCW-1:0] r_frame_cnt;

   logic w_accept;
   logic w_trig;
   logic w_tmo_fire;

   assign cfg_ready = (r_state != PEND);
   assign w_accept  = cfg_valid && cfg_ready;

`ifdef FILT_SCHED_TIMEOUT_EN
   logic r_timeout;

   sof_watchdog #(
      .TOW         (TOW),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_sof_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (r_state == PEND),
      .clr    (sb_mon.sof || w_accept),
      .expire (w_tmo_fire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_tmo_fire;
      end
   end

   assign timeout = r_timeout;
`else
   localparam int c_unused_wd = TOW + TIMEOUT_CYC;
   assign w_tmo_fire = 1'b0;
`endif

   // A forced timeout commit behaves exactly like a sof while pending.
   assign w_trig = sb_mon.sof || w_tmo_fire;

   always_comb begin
      w_state_nx  = r_state;
      w_ctrl_nx   = r_ctrl;
      w_base_nx   = r_base;
      w_rem_nx    = r_rem;
      w_commit_nx = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nx = PEND;
            end
         end
         PEND: begin
            if (w_trig) begin
               w_commit_nx = 1'b1;
               w_ctrl_nx   = r_shadow_ctrl;
               if (r_shadow_frames == 8'd0) begin
                  w_base_nx  = r_shadow_ctrl;
                  w_state_nx = IDLE;
               end else begin
                  w_rem_nx   = r_shadow_frames;
                  w_state_nx = HOLD;
               end
            end
         end
         HOLD: begin
            // A new request abandons the override; ctrl_out waits for its commit.
            if (w_accept) begin
               w_state_nx = PEND;
               w_rem_nx   = 8'd0;
            end else if (sb_mon.sof) begin
               if (r_rem == 8'd1) begin
                  w_ctrl_nx   = r_base;
                  w_commit_nx = 1'b1;
                  w_rem_nx    = 8'd0;
                  w_state_nx  = IDLE;
               end else begin
                  w_rem_nx = r_rem - 8'd1;
               end
            end
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= IDLE;
         r_ctrl          <= '0;
         r_base          <= '0;
         r_shadow_ctrl   <= '0;
         r_shadow_frames <= 8'd0;
         r_rem           <= 8'd0;
         r_commit        <= 1'b0;
         r_frame_cnt     <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_ctrl   <= w_ctrl_nx;
         r_base   <= w_base_nx;
         r_rem    <= w_rem_nx;
         r_commit <= w_commit_nx;
         if (w_accept) begin
            r_shadow_ctrl   <= filt_ctrl_t'(cfg_ctrl);
            r_shadow_frames <= cfg_frames;
         end
         if (sb_mon.sof) begin
            r_frame_cnt <= r_frame_cnt + FCW'(1);
         end
      end
   end

   assign ctrl_out  = r_ctrl;
   assign commit    = r_commit;
   assign frame_cnt = r_frame_cnt;
   assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_filt_ctrl_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_filt_ctrl_sched : directed self-checking bench for filt_ctrl_sched
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_filt_ctrl_sched;

   localparam int FCW = 4;
`ifdef FILT_SCHED_TIMEOUT_EN
   localparam int TMO = 100;
`else
   localparam int TMO = 2000000;
`endif

   logic           clk        = 1'b0;
   logic           rst_n      = 1'b0;
   logic           cfg_valid  = 1'b0;
   logic           cfg_ready;
   logic [1:0]     cfg_ctrl   = 2'b00;
   logic [7:0]     cfg_frames = 8'd0;
   logic [1:0]     ctrl_out;
   logic           commit;
   logic [FCW-1:0] frame_cnt;
   logic           busy;
`ifdef FILT_SCHED_TIMEOUT_EN
   logic           timeout;
`endif

   int total   = 0;
   int bad     = 0;
   int ncommit = 0;
   int snap    = 0;

   vid_sideband_if sb ();

   filt_ctrl_sched #(
      .FCW         (FCW),
      .TOW         (24),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ctrl   (cfg_ctrl),
      .cfg_frames (cfg_frames),
      .sb_mon     (sb),
      .ctrl_out   (ctrl_out),
      .commit     (commit),
      .frame_cnt  (frame_cnt),
      .busy       (busy)
`ifdef FILT_SCHED_TIMEOUT_EN
      ,
      .timeout    (timeout)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (commit === 1'b1) ncommit++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic request(input logic [1:0] c, input logic [7:0] f);
      cfg_valid  = 1'b1;
      cfg_ctrl   = c;
      cfg_frames = f;
      tick(1);
      cfg_valid  = 1'b0;
   endtask

   task automatic sof_step(input string tag, input logic [1:0] exp_ctrl, input logic exp_commit);
      sb.sof = 1'b1;
      tick(1);
      sb.sof = 1'b0;
      check({tag, "_ctrl"}, 32'(ctrl_out), 32'(exp_ctrl));
      check({tag, "_commit"}, 32'(commit), 32'(exp_commit));
      tick(1);
      check({tag, "_commit_clr"}, 32'(commit), 32'd0);
   endtask

   initial begin
      sb.sof = 1'b0;

      // reset state
      tick(2);
      check("rst_ctrl", 32'(ctrl_out), 32'd0);
      check("rst_commit", 32'(commit), 32'd0);
      check("rst_fcnt", 32'(frame_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(cfg_ready), 32'd1);
      rst_n = 1'b1;
      tick(1);

      // persistent commit
      request(2'b01, 8'd0);
      check("pers_busy", 32'(busy), 32'd1);
      check("pers_ready", 32'(cfg_ready), 32'd0);
      tick(2);
      check("pers_wait_ctrl", 32'(ctrl_out), 32'd0);
      sof_step("pers", 2'b01, 1'b1);
      check("pers_idle", 32'(busy), 32'd0);
      check("pers_fcnt", 32'(frame_cnt), 32'd1);

      // 3-frame override then revert
      snap = ncommit;
      request(2'b11, 8'd3);
      sof_step("ovr1", 2'b11, 1'b1);
      check("ovr_hold", 32'(busy), 32'd1);
      sof_step("ovr2", 2'b11, 1'b0);
      sof_step("ovr3", 2'b11, 1'b0);
      sof_step("ovr4", 2'b01, 1'b1);
      check("ovr_idle", 32'(busy), 32'd0);
      sof_step("ovr5", 2'b01, 1'b0);
      check("ovr_npulse", 32'(ncommit - snap), 32'd2);
      check("ovr_fcnt", 32'(frame_cnt), 32'd6);

      // request coincident with sof
      cfg_valid  = 1'b1;
      cfg_ctrl   = 2'b10;
      cfg_frames = 8'd0;
      sb.sof     = 1'b1;
      tick(1);
      cfg_valid  = 1'b0;
      sb.sof     = 1'b0;
      check("coll_ctrl", 32'(ctrl_out), 32'h1);
      check("coll_commit", 32'(commit), 32'd0);
      check("coll_busy", 32'(busy), 32'd1);
      sof_step("coll", 2'b10, 1'b1);
      check("coll_fcnt", 32'(frame_cnt), 32'd8);

      // preempt override with remaining==2
      request(2'b11, 8'd3);
      sof_step("pre_c", 2'b11, 1'b1);
      sof_step("pre_d", 2'b11, 1'b0);
      request(2'b00, 8'd0);
      check("pre_ctrl_hold", 32'(ctrl_out), 32'h3);
      check("pre_busy", 32'(busy), 32'd1);
      check("pre_ready", 32'(cfg_ready), 32'd0);
      tick(3);
      check("pre_ctrl_wait", 32'(ctrl_out), 32'h3);
      sof_step("pre_x", 2'b00, 1'b1);
      check("pre_idle", 32'(busy), 32'd0);

      // single-frame override reverts to base 00
      request(2'b01, 8'd1);
      sof_step("n1_on", 2'b01, 1'b1);
      sof_step("n1_off", 2'b00, 1'b1);
      check("n1_fcnt", 32'(frame_cnt), 32'd13);

      // frame counter wrap at 2^FCW
      sof_step("wrap_a", 2'b00, 1'b0);
      sof_step("wrap_b", 2'b00, 1'b0);
      sof_step("wrap_c", 2'b00, 1'b0);
      check("wrap_zero", 32'(frame_cnt), 32'd0);
      sof_step("wrap_d", 2'b00, 1'b0);
      check("wrap_one", 32'(frame_cnt), 32'd1);

      // reset in the middle of an override
      request(2'b11, 8'd5);
      sof_step("rh", 2'b11, 1'b1);
      snap = ncommit;
      rst_n = 1'b0;
      #1;
      check("rh_ctrl", 32'(ctrl_out), 32'd0);
      check("rh_busy", 32'(busy), 32'd0);
      check("rh_fcnt", 32'(frame_cnt), 32'd0);
      check("rh_commit", 32'(commit), 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      sof_step("rh_post", 2'b00, 1'b0);
      check("rh_npulse", 32'(ncommit - snap), 32'd0);

      // reset while pending
      request(2'b10, 8'd0);
      check("rp_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rp_busy_rst", 32'(busy), 32'd0);
      check("rp_ready", 32'(cfg_ready), 32'd1);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      sof_step("rp_post", 2'b00, 1'b0);

`ifdef FILT_SCHED_TIMEOUT_EN
      // forced commit after TIMEOUT_CYC cycles without sof
      request(2'b01, 8'd0);
      check("tmo_init", 32'(timeout), 32'd0);
      tick(99);
      check("tmo_pre_ctrl", 32'(ctrl_out), 32'd0);
      check("tmo_pre_flag", 32'(timeout), 32'd0);
      check("tmo_pre_busy", 32'(busy), 32'd1);
      tick(1);
      check("tmo_ctrl", 32'(ctrl_out), 32'h1);
      check("tmo_commit", 32'(commit), 32'd1);
      check("tmo_flag", 32'(timeout), 32'd1);
      check("tmo_busy", 32'(busy), 32'd0);
      tick(1);
      check("tmo_flag_clr", 32'(timeout), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
